intel_fpga_axi_gpio_ctrl: RTL and testbench
===========================================

Name: intel_fpga_axi_gpio_ctrl

Overview:
AXI4-Lite master that sequences the GPIO register block. It schedules two activities over one AXI4-Lite link, one transaction outstanding at a time:
- a periodic GPI poll, which produces a local change event;
- GPO masked-update commands from local logic, applied as full-register writes from a shadow copy.

It sits between local control logic and the GPIO slave, so that logic needs no bus access of its own.

Parameters:
P_ADDR_WIDTH, 4, AXI address width
P_DATA_WIDTH, 32, AXI data width
P_GPI_WIDTH, 32, GPI field width (<= P_DATA_WIDTH)
P_GPO_WIDTH, 32, GPO field width (<= P_DATA_WIDTH)
P_GPO_ADDR, 'h0, GPO register byte address
P_GPI_ADDR, 'h4, GPI register byte address
P_GPO_DEFAULT, 32'h0, shadow value before the INIT read completes
P_POLL_CYCLES, 1024, poll period in clocks (>= 2)

Ports:
s_axi_aclk  in  1  clock
s_axi_aresetn  in  1  reset
m_axi_awaddr  out  P_ADDR_WIDTH  write address
m_axi_awvalid  out  1  write address valid
m_axi_awready  in  1  write address ready
m_axi_wdata  out  P_DATA_WIDTH  write data
m_axi_wstrb  out  P_DATA_WIDTH/8  write strobes, always all-ones
m_axi_wvalid  out  1  write data valid
m_axi_wready  in  1  write data ready
m_axi_bresp  in  2  write response
m_axi_bvalid  in  1  write response valid
m_axi_bready  out  1  write response ready
m_axi_araddr  out  P_ADDR_WIDTH  read address
m_axi_arvalid  out  1  read address valid
m_axi_arready  in  1  read address ready
m_axi_rdata  in  P_DATA_WIDTH  read data
m_axi_rresp  in  2  read response
m_axi_rvalid  in  1  read data valid
m_axi_rready  out  1  read data ready
cmd_valid  in  1  GPO update request
cmd_ready  out  1  one-cycle accept pulse
cmd_data  in  P_GPO_WIDTH  new GPO bit values
cmd_mask  in  P_GPO_WIDTH  1 = take the bit from cmd_data
gpo_shadow  out  P_GPO_WIDTH  last GPO value confirmed by the slave
gpi_value  out  P_GPI_WIDTH  last polled GPI value
gpi_change  out  1  one-cycle pulse when the polled GPI value differs from the previous poll
err  out  1  one-cycle pulse on a SLVERR/DECERR response

Behaviour:
- Reset: s_axi_aresetn, asynchronous, active-low; clock s_axi_aclk.
- Reset values:
  - all m_axi valid/ready outputs = 0;
  - cmd_ready, gpi_change, err = 0;
  - gpi_value = 0;
  - gpo_shadow = P_GPO_DEFAULT;
  - poll timer = P_POLL_CYCLES-1; poll_pending = 0; first_poll = 1; last_op = READ.
- Reset mid-transaction aborts immediately; all valids drop. The slave must share the reset.
- States: INIT_RD, INIT_WAIT, IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP.
- INIT (first state after reset):
  - Read P_GPO_ADDR.
  - OKAY: load gpo_shadow from rdata.
  - Error: pulse err, keep the default.
  - Either way, go to IDLE.
- Poll timer:
  - Free-runs in all states and decrements each clock.
  - At 0 it sets poll_pending and reloads P_POLL_CYCLES-1.
  - Expiry while poll_pending is already set is dropped; polls do not queue.
- IDLE arbitration, evaluated each cycle:
  - Poll goes first if poll_pending && (last_op == WRITE || !cmd_valid).
  - Otherwise, if cmd_valid, the command goes.
  - This guarantees a poll is served within one write of becoming pending.
- Command path:
  - The cmd_ready pulse captures new = (gpo_shadow & ~cmd_mask) | (cmd_data & cmd_mask).
  - If new == gpo_shadow, the command completes with no bus traffic and the FSM stays in IDLE.
  - Otherwise go to WR_REQ.
- WR_REQ:
  - awvalid and wvalid are asserted together on the cycle after accept.
  - Each deasserts independently after its own handshake.
  - Go to WR_RESP once both handshakes are done.
- WR_RESP:
  - bready = 1.
  - On bvalid with OKAY: gpo_shadow <= new.
  - Otherwise: pulse err, shadow unchanged.
  - Set last_op = WRITE and return to IDLE.
- RD_REQ: arvalid at P_GPI_ADDR until arready; clear poll_pending on entry.
- RD_RESP:
  - rready = 1.
  - On rvalid with OKAY: gpi_value <= rdata[P_GPI_WIDTH-1:0]. Pulse gpi_change if the value differs and first_poll == 0. Then clear first_poll.
  - On error: pulse err, gpi_value held.
  - Set last_op = READ.
- Protocol rules:
  - awaddr, wdata and araddr are stable while valid.
  - A valid is never withdrawn before its ready.
  - cmd_ready is never asserted outside IDLE.
- Latency: a command accepted in cycle N presents aw/w in cycle N+1. With a zero-wait slave the shadow updates in cycle N+3.

Decomposition:
- Package intel_fpga_axi_gpio_ctrl_pkg holds:
  - state enum;
  - AXI response constants (OKAY 2'b00, SLVERR 2'b10, DECERR 2'b11);
  - op enum {READ, WRITE}.
- Sub-module intel_fpga_gpio_poll_timer: reload counter with an expiry pulse.

Test Plan:
1. Reset, slave GPO = 0x0000_00A5 -> INIT read at 0x0; gpo_shadow = 0xA5; no err.
2. cmd_data = 0xFF00, cmd_mask = 0x0F00, shadow 0xA5 -> one write, wdata = 0x0FA5, wstrb = 0xF; gpo_shadow = 0x0FA5 after bvalid.
3. Command identical to the shadow -> cmd_ready pulse, zero AXI transactions, shadow unchanged.
4. P_POLL_CYCLES = 16, gpi toggles 0x1 -> 0x3 -> reads at 0x4 every 16 clocks; gpi_change pulses exactly once, not on the first poll.
5. cmd_valid held continuously plus poll expiry -> grants alternate write/read; no poll delayed by more than one write.
6. Slave returns SLVERR on a write with awready delayed 3 cycles and wready immediate -> valids drop independently; err pulses once; shadow unchanged.

Source files
------------

// File: rtl/intel_fpga_axi_gpio_ctrl_pkg.sv
// intel_fpga_axi_gpio_ctrl_pkg: shared types and AXI response codes for the GPIO sequencer
package intel_fpga_axi_gpio_ctrl_pkg;
  typedef enum logic [2:0] {INIT_RD, INIT_WAIT, IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP} state_t;
  typedef enum logic {READ, WRITE} op_t;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
endpackage

// File: rtl/intel_fpga_axi_gpio_ctrl_if.sv
// intel_fpga_axi_gpio_ctrl_if: AXI4-Lite link between the sequencer and the GPIO slave
interface intel_fpga_axi_gpio_ctrl_if #(
  parameter int P_ADDR_WIDTH = 4,
  parameter int P_DATA_WIDTH = 32
);
  logic [P_ADDR_WIDTH-1:0]   awaddr;
  logic                      awvalid;
  logic                      awready;
  logic [P_DATA_WIDTH-1:0]   wdata;
  logic [P_DATA_WIDTH/8-1:0] wstrb;
  logic                      wvalid;
  logic                      wready;
  logic [1:0]                bresp;
  logic                      bvalid;
  logic                      bready;
  logic [P_ADDR_WIDTH-1:0]   araddr;
  logic                      arvalid;
  logic                      arready;
  logic [P_DATA_WIDTH-1:0]   rdata;
  logic [1:0]                rresp;
  logic                      rvalid;
  logic                      rready;
  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/intel_fpga_gpio_poll_timer.sv
// intel_fpga_gpio_poll_timer: free-running reload counter emitting a pulse every P_CYCLES clocks
module intel_fpga_gpio_poll_timer #(
  parameter int P_CYCLES = 1024
) (
  input  logic s_axi_aclk,
  input  logic s_axi_aresetn,
  output logic expire
);
  localparam int W = $clog2(P_CYCLES);
  logic [W-1:0] cnt;
  assign expire = cnt == '0;
  // count down and reload on expiry
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn)
    if (!s_axi_aresetn) cnt <= W'(P_CYCLES - 1);
    else cnt <= expire ? W'(P_CYCLES - 1) : cnt - 1'b1;
endmodule

// File: rtl/intel_fpga_axi_gpio_ctrl.sv
// intel_fpga_axi_gpio_ctrl: AXI4-Lite master applying masked GPO updates and polling GPI
module intel_fpga_axi_gpio_ctrl
  import intel_fpga_axi_gpio_ctrl_pkg::*;
#(
  parameter int                    P_ADDR_WIDTH  = 4,
  parameter int                    P_DATA_WIDTH  = 32,
  parameter int                    P_GPI_WIDTH   = 32,
  parameter int                    P_GPO_WIDTH   = 32,
  parameter logic [P_ADDR_WIDTH-1:0] P_GPO_ADDR  = 'h0,
  parameter logic [P_ADDR_WIDTH-1:0] P_GPI_ADDR  = 'h4,
  parameter logic [P_GPO_WIDTH-1:0]  P_GPO_DEFAULT = '0,
  parameter int                    P_POLL_CYCLES = 1024
) (
  input  logic                   s_axi_aclk,
  input  logic                   s_axi_aresetn,
  intel_fpga_axi_gpio_ctrl_if.master m_axi,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [P_GPO_WIDTH-1:0] cmd_data,
  input  logic [P_GPO_WIDTH-1:0] cmd_mask,
  output logic [P_GPO_WIDTH-1:0] gpo_shadow,
  output logic [P_GPI_WIDTH-1:0] gpi_value,
  output logic                   gpi_change,
  output logic                   err
);
  state_t state, state_nx;
  op_t last_op;
  logic run, poll_pending, first_poll, aw_done, w_done, expire, poll_go, cmd_go;
  logic [P_GPO_WIDTH-1:0] wr_val, cmd_val;

  intel_fpga_gpio_poll_timer #(.P_CYCLES(P_POLL_CYCLES)) u_timer (
    .s_axi_aclk(s_axi_aclk), .s_axi_aresetn(s_axi_aresetn), .expire(expire)
  );

  assign cmd_val = (gpo_shadow & ~cmd_mask) | (cmd_data & cmd_mask);
  assign poll_go = state == IDLE && poll_pending && (last_op == WRITE || !cmd_valid);
  assign cmd_go  = state == IDLE && cmd_valid && !poll_go;

  assign m_axi.awaddr  = P_GPO_ADDR;
  assign m_axi.awvalid = state == WR_REQ && !aw_done;
  assign m_axi.wdata   = P_DATA_WIDTH'(wr_val);
  assign m_axi.wstrb   = '1;
  assign m_axi.wvalid  = state == WR_REQ && !w_done;
  assign m_axi.bready  = state == WR_RESP;
  assign m_axi.araddr  = state == RD_REQ ? P_GPI_ADDR : P_GPO_ADDR;
  assign m_axi.arvalid = (state == INIT_RD && run) || state == RD_REQ;
  assign m_axi.rready  = state == INIT_WAIT || state == RD_RESP;

  // state register; run holds off the INIT read until the first clock after reset
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn)
    if (!s_axi_aresetn) state <= INIT_RD;
    else state <= state_nx;

  // next-state and command accept; cmd_ready only ever rises in IDLE
  always_comb begin
    state_nx  = state;
    cmd_ready = 1'b0;
    case (state)
      INIT_RD:   if (run && m_axi.arready) state_nx = INIT_WAIT;
      INIT_WAIT: if (m_axi.rvalid) state_nx = IDLE;
      IDLE: begin
        cmd_ready = cmd_go;
        state_nx  = poll_go ? RD_REQ : (cmd_go && cmd_val != gpo_shadow) ? WR_REQ : IDLE;
      end
      WR_REQ:    if ((aw_done || m_axi.awready) && (w_done || m_axi.wready)) state_nx = WR_RESP;
      WR_RESP:   if (m_axi.bvalid) state_nx = IDLE;
      RD_REQ:    if (m_axi.arready) state_nx = RD_RESP;
      RD_RESP:   if (m_axi.rvalid) state_nx = IDLE;
      default:   state_nx = INIT_RD;
    endcase
  end

  // datapath: poll bookkeeping, write channel tracking and response handling
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn)
    if (!s_axi_aresetn) begin
      run          <= 1'b0;
      poll_pending <= 1'b0;
      first_poll   <= 1'b1;
      last_op      <= READ;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      wr_val       <= '0;
      gpo_shadow   <= P_GPO_DEFAULT;
      gpi_value    <= '0;
      gpi_change   <= 1'b0;
      err          <= 1'b0;
    end else begin
      run          <= 1'b1;
      gpi_change   <= 1'b0;
      err          <= 1'b0;
      poll_pending <= !poll_go && (poll_pending || expire);
      if (cmd_ready) begin
        wr_val  <= cmd_val;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (m_axi.awvalid && m_axi.awready) aw_done <= 1'b1;
      if (m_axi.wvalid && m_axi.wready) w_done <= 1'b1;
      if (state == INIT_WAIT && m_axi.rvalid) begin
        if (m_axi.rresp == RESP_OKAY) gpo_shadow <= m_axi.rdata[P_GPO_WIDTH-1:0];
        else err <= 1'b1;
      end
      if (state == WR_RESP && m_axi.bvalid) begin
        last_op <= WRITE;
        if (m_axi.bresp == RESP_OKAY) gpo_shadow <= wr_val;
        else err <= 1'b1;
      end
      if (state == RD_RESP && m_axi.rvalid) begin
        last_op <= READ;
        if (m_axi.rresp == RESP_OKAY) begin
          gpi_value  <= m_axi.rdata[P_GPI_WIDTH-1:0];
          gpi_change <= !first_poll && m_axi.rdata[P_GPI_WIDTH-1:0] != gpi_value;
          first_poll <= 1'b0;
        end else err <= 1'b1;
      end
    end
endmodule

// File: tb/tb_intel_fpga_axi_gpio_ctrl.sv
// tb_intel_fpga_axi_gpio_ctrl: directed bench driving the sequencer against a small AXI-Lite slave model
module tb_intel_fpga_axi_gpio_ctrl;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;
  logic clk, rstn;
  logic cmd_valid, cmd_ready, gpi_change, err;
  logic [31:0] cmd_data, cmd_mask, gpo_shadow, gpi_value;
  logic [31:0] gpo_init, gpo_reg, gpi_reg, wdata_q;
  logic got_aw, got_w, wr_err, win;
  logic [3:0] first_araddr, last_araddr;
  int aw_delay, aw_cnt;
  int cyc = 0, n_ar = 0, n_aw = 0, n_err = 0, n_chg = 0;
  int prev_ar_cyc = 0, last_gap = 0, max_gap = 0;
  int n_cmp = 0, n_bad = 0;

  intel_fpga_axi_gpio_ctrl_if #(.P_ADDR_WIDTH(4), .P_DATA_WIDTH(32)) bus ();

  intel_fpga_axi_gpio_ctrl #(.P_POLL_CYCLES(16)) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rstn), .m_axi(bus),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
    .gpo_shadow(gpo_shadow), .gpi_value(gpi_value), .gpi_change(gpi_change), .err(err)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  assign bus.awready = aw_cnt >= aw_delay;
  assign bus.wready  = 1'b1;
  assign bus.arready = 1'b1;

  // slave model: GPO register at 0x0, GPI at 0x4, optional aw stall and write error
  always @(posedge clk or negedge rstn)
    if (!rstn) begin
      bus.rvalid <= 1'b0;
      bus.bvalid <= 1'b0;
      bus.rdata  <= '0;
      bus.rresp  <= OKAY;
      bus.bresp  <= OKAY;
      got_aw     <= 1'b0;
      got_w      <= 1'b0;
      aw_cnt     <= 0;
      wdata_q    <= '0;
      gpo_reg    <= gpo_init;
    end else begin
      if (bus.arvalid && bus.arready) begin
        bus.rvalid <= 1'b1;
        bus.rdata  <= bus.araddr == 4'h0 ? gpo_reg : gpi_reg;
        bus.rresp  <= OKAY;
      end else if (bus.rvalid && bus.rready) bus.rvalid <= 1'b0;
      aw_cnt <= (bus.awvalid && !bus.awready) ? aw_cnt + 1 : 0;
      if (bus.awvalid && bus.awready) got_aw <= 1'b1;
      if (bus.wvalid && bus.wready) begin
        got_w   <= 1'b1;
        wdata_q <= bus.wdata;
      end
      if ((got_aw || (bus.awvalid && bus.awready)) && (got_w || (bus.wvalid && bus.wready)) && !bus.bvalid) begin
        bus.bvalid <= 1'b1;
        bus.bresp  <= wr_err ? SLVERR : OKAY;
        got_aw     <= 1'b0;
        got_w      <= 1'b0;
        if (!wr_err) gpo_reg <= got_w ? wdata_q : bus.wdata;
      end else if (bus.bvalid && bus.bready) bus.bvalid <= 1'b0;
    end

  // event counters and poll spacing observed on the bus
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (err) n_err <= n_err + 1;
    if (gpi_change) n_chg <= n_chg + 1;
    if (bus.awvalid && bus.awready) n_aw <= n_aw + 1;
    if (bus.arvalid && bus.arready) begin
      if (n_ar == 0) first_araddr <= bus.araddr;
      last_araddr <= bus.araddr;
      n_ar <= n_ar + 1;
      if (bus.araddr == 4'h4) begin
        last_gap    <= cyc - prev_ar_cyc;
        prev_ar_cyc <= cyc;
        if (win && prev_ar_cyc != 0 && cyc - prev_ar_cyc > max_gap) max_gap <= cyc - prev_ar_cyc;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_cmd(input logic [31:0] d, input logic [31:0] m, output logic seen);
    cmd_data  = d;
    cmd_mask  = m;
    cmd_valid = 1'b1;
    seen      = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      #1 seen = cmd_ready;
      if (!seen) @(negedge clk);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_polls(input int target);
    for (int i = 0; i < 60 && n_ar < target; i++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  logic seen, acc;
  logic [31:0] d, last_acc;
  int a_aw, a_ar, e0, c0;

  initial begin
    rstn = 0; cmd_valid = 1; cmd_data = '0; cmd_mask = '0;
    gpo_init = 32'hA5; gpi_reg = 32'h1; aw_delay = 0; wr_err = 0; win = 0;
    repeat (3) @(negedge clk);
    chk("rst_arvalid", bus.arvalid, 0);
    chk("rst_awvalid", bus.awvalid, 0);
    chk("rst_wvalid", bus.wvalid, 0);
    chk("rst_readies", {bus.bready, bus.rready}, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_pulses", {gpi_change, err}, 0);
    chk("rst_gpi_value", gpi_value, 0);
    chk("rst_gpo_shadow", gpo_shadow, 0);
    cmd_valid = 0;
    rstn = 1;

    repeat (6) @(negedge clk);
    chk("t1_init_addr", first_araddr, 4'h0);
    chk("t1_init_reads", n_ar, 1);
    chk("t1_shadow", gpo_shadow, 32'hA5);
    chk("t1_err", n_err, 0);

    a_aw = n_aw;
    send_cmd(32'hFF00, 32'h0F00, seen);
    chk("t2_accept", seen, 1);
    chk("t2_aw_w_valid", {bus.awvalid, bus.wvalid}, 2'b11);
    chk("t2_awaddr", bus.awaddr, 4'h0);
    chk("t2_wdata", bus.wdata, 32'h0FA5);
    chk("t2_wstrb", bus.wstrb, 4'hF);
    @(negedge clk);
    chk("t2_shadow_n2", gpo_shadow, 32'hA5);
    @(negedge clk);
    chk("t2_shadow_n3", gpo_shadow, 32'h0FA5);
    repeat (3) @(negedge clk);
    chk("t2_writes", 32'(n_aw - a_aw), 1);
    chk("t2_slave_gpo", gpo_reg, 32'h0FA5);

    a_aw = n_aw;
    send_cmd(32'h0FA5, 32'hFFFF_FFFF, seen);
    chk("t3_accept", seen, 1);
    chk("t3_no_awvalid", bus.awvalid, 0);
    repeat (20) @(negedge clk);
    chk("t3_writes", 32'(n_aw - a_aw), 0);
    chk("t3_shadow", gpo_shadow, 32'h0FA5);

    wait_polls(2);
    chk("t4_first_value", gpi_value, 32'h1);
    chk("t4_first_no_chg", n_chg, 0);
    gpi_reg = 32'h3;
    a_ar = n_ar;
    wait_polls(a_ar + 1);
    chk("t4_addr", last_araddr, 4'h4);
    chk("t4_value", gpi_value, 32'h3);
    chk("t4_chg_once", n_chg, 1);
    a_ar = n_ar;
    wait_polls(a_ar + 1);
    chk("t4_steady_no_chg", n_chg, 1);
    chk("t4_period", 32'(last_gap), 16);

    win = 1; a_aw = n_aw; a_ar = n_ar;
    d = 32'h1234; last_acc = gpo_shadow; acc = 0;
    cmd_mask = '1; cmd_data = d; cmd_valid = 1;
    for (int i = 0; i < 100; i++) begin
      #1 acc = cmd_ready;
      if (acc) last_acc = d;
      @(negedge clk);
      if (acc) begin
        d = ~d;
        cmd_data = d;
      end
    end
    cmd_valid = 0; win = 0;
    repeat (8) @(negedge clk);
    chk("t5_reads", 32'(n_ar - a_ar >= 5), 1);
    chk("t5_writes", 32'(n_aw - a_aw >= 20), 1);
    chk("t5_max_poll_gap", 32'(max_gap <= 20 && max_gap >= 16), 1);
    chk("t5_shadow", gpo_shadow, last_acc);

    aw_delay = 3; wr_err = 1; e0 = n_err; c0 = n_aw;
    send_cmd(32'hDEAD_BEEF, 32'hFFFF_FFFF, seen);
    chk("t6_accept", seen, 1);
    chk("t6_valids_n1", {bus.awvalid, bus.wvalid}, 2'b11);
    @(negedge clk);
    chk("t6_valids_n2", {bus.awvalid, bus.wvalid}, 2'b10);
    repeat (2) @(negedge clk);
    chk("t6_aw_n4", bus.awvalid, 1);
    @(negedge clk);
    chk("t6_aw_n5", bus.awvalid, 0);
    repeat (5) @(negedge clk);
    chk("t6_err_once", 32'(n_err - e0), 1);
    chk("t6_aw_count", 32'(n_aw - c0), 1);
    chk("t6_shadow", gpo_shadow, last_acc);
    aw_delay = 0; wr_err = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
